// File: rtl/fb_write_arbiter_pkg.sv
// Shared types, defaults and engine indices for the frame-buffer write arbiter.
package fb_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 5;
  localparam int DEF_ADDR_W    = 17;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 64;
  localparam int GRANT_W       = 3;

  localparam int REQ_SOFT_RST  = 0;
  localparam int REQ_TEST_PAT  = 1;
  localparam int REQ_LINE_DRAW = 2;
  localparam int REQ_RECT_FILL = 3;
  localparam int REQ_BLIT      = 4;

  // Index reached by stepping 'step' places past 'base' around a ring of n engines.
  function automatic logic [GRANT_W-1:0] rr_index(input logic [GRANT_W-1:0] base,
                                                  input int step, input int n);
    int sum;
    sum = (int'(base) + step) % n;
    return GRANT_W'(sum);
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Engine-side and frame-buffer-side signals of the pixel write arbiter.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ = fb_write_arbiter_pkg::DEF_NUM_REQ,
  parameter int ADDR_W  = fb_write_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W  = fb_write_arbiter_pkg::DEF_DATA_W
);
  // A beat moves when rts and rtr are both high at a rising clk edge; the
  // sender holds rts/addr/data/last stable until then, and rtr never waits on
  // anything but the receiver's own state (rtr may depend combinationally on fb_rtr).
  logic [NUM_REQ-1:0]        req_rts;
  logic [NUM_REQ-1:0]        req_rtr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      fb_rts;
  logic                      fb_rtr;
  logic [ADDR_W-1:0]         fb_addr;
  logic [DATA_W-1:0]         fb_data;
  logic [2:0]                grant_id;
  logic                      busy;

  modport master (
    output req_rts, req_addr, req_data, req_last, fb_rtr,
    input  req_rtr, fb_rts, fb_addr, fb_data, grant_id, busy
  );

  modport slave (
    input  req_rts, req_addr, req_data, req_last, fb_rtr,
    output req_rtr, fb_rts, fb_addr, fb_data, grant_id, busy
  );
endinterface

// File: rtl/fb_write_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_priority_pick
  import fb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] grant,
  output logic               any_req
);

  logic [7:0]         req_pad;
  logic [GRANT_W-1:0] idx;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    // Walk from the farthest ring position to the nearest so the nearest wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = rr_index(last_grant, k, NUM_REQ);
      if (req_pad[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer write port among drawing engines: round-robin, burst
// hold, MAX_BURST cap, registered output. FB_ARB_PRIO0_EN: engine 0 wins every idle pick.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               clk,
  input  logic               rst_,
  fb_write_arbiter_if.slave  bus,
  output arb_state_e         dbg_state
);

  localparam int CNT_W = $clog2(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, last_grant_q, rr_id, pick_id;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               prio_hold_q, prio_win, any_req;
  logic               fb_rts_q;
  logic [ADDR_W-1:0]  fb_addr_q, hold_addr;
  logic [DATA_W-1:0]  fb_data_q, hold_data;
  logic               hold_rts, hold_last, out_free, xfc_grant, cap_hit, rel_grant;
  logic [NUM_REQ-1:0] req_rtr;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.req_rts),
    .last_grant (last_grant_q),
    .grant      (rr_id),
    .any_req    (any_req)
  );

`ifdef FB_ARB_PRIO0_EN
  assign prio_win = bus.req_rts[REQ_SOFT_RST];
`else
  assign prio_win = 1'b0;
`endif
  assign pick_id = prio_win ? GRANT_W'(REQ_SOFT_RST) : rr_id;

  // Holder's beat, selected by the registered grant.
  always_comb begin
    hold_rts  = 1'b0;
    hold_last = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GRANT_W'(i)) begin
        hold_rts  = bus.req_rts[i];
        hold_last = bus.req_last[i];
        hold_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        hold_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_free  = ~fb_rts_q | bus.fb_rtr;
  assign xfc_grant = (state_q == ST_BUSY) & hold_rts & out_free;
  assign cap_hit   = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign rel_grant = (state_q == ST_BUSY) & (~hold_rts | (xfc_grant & (hold_last | cap_hit)));

  always_comb begin
    state_d = state_q;
    req_rtr = '0;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_BUSY;
      ST_BUSY: begin
        for (int i = 0; i < NUM_REQ; i++)
          req_rtr[i] = (grant_id_q == GRANT_W'(i)) & out_free;
        if (rel_grant) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      prio_hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && any_req) begin
        grant_id_q  <= pick_id;
        beat_cnt_q  <= '0;
        prio_hold_q <= prio_win;
      end else if (xfc_grant) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
      // A priority grant leaves the round-robin pointer where it was.
      if (rel_grant && !prio_hold_q) last_grant_q <= grant_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fb_rts_q  <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else if (xfc_grant) begin
      fb_rts_q  <= 1'b1;
      fb_addr_q <= hold_addr;
      fb_data_q <= hold_data;
    end else if (bus.fb_rtr) begin
      fb_rts_q <= 1'b0;
    end
  end

  assign bus.req_rtr  = req_rtr;
  assign bus.fb_rts   = fb_rts_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q == ST_BUSY);
  assign dbg_state    = state_q;

endmodule
